serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx.sv | 161 ++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serialises the top len bits of data MSB-first on x and counts the "110" patterns
// emitted within each frame; outputs are registered and the FSM is IDLE -> SHIFT -> DONE.
module serial_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        data,
    input  logic [$clog2(WIDTH):0]  len,
    output logic                    x,
    output logic                    valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CNTW-1:0]         cnt110
);

    localparam int LW = $clog2(WIDTH) + 1;
    localparam logic [LW-1:0]   LEN_MAX = LW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [LW-1:0]     rem_q, rem_d;
    logic [1:0]        hist_q, hist_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              x_q, x_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              len_ok_s;
    logic              next_bit_s;

    assign len_ok_s   = (len != '0) && (len <= LEN_MAX);
    assign next_bit_s = shreg_q[WIDTH-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rem_q counts bits still to show including the one on x
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && len_ok_s) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (rem_q == LW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; the first bit leaves on the accepting edge
    always_comb begin
        shreg_d = shreg_q;
        rem_d   = rem_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        x_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok_s) begin
                        shreg_d = {data[WIDTH-2:0], 1'b0};
                        rem_d   = len;
                        hist_d  = {1'b0, data[WIDTH-1]};
                        cnt_d   = '0;
                        x_d     = data[WIDTH-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (rem_q != LW'(1)) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    rem_d   = rem_q - LW'(1);
                    hist_d  = {hist_q[0], next_bit_s};
                    x_d     = next_bit_s;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    if (!next_bit_s && (hist_q == 2'b11) && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    done_d = 1'b1;
                end
            end
            S_DONE:  done_d = 1'b0;
            default: done_d = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            rem_q   <= '0;
            hist_q  <= 2'b00;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign x      = x_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign cnt110 = cnt_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomised and directed bench for serial_pattern_tx; expected streams and 110 counts
// come from a frame-level model. CNTW is narrowed so counter saturation is reachable.
module tb_serial_pattern_tx;

    localparam int WIDTH   = 16;
    localparam int CNTW    = 2;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  data;
    logic [4:0]        len;
    logic              x, valid, busy, done, err;
    logic [CNTW-1:0]   cnt110;

    int checks;
    int errors;
    int last_cnt;

    serial_pattern_tx #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
        .x(x), .valid(valid), .busy(busy), .done(done), .err(err), .cnt110(cnt110)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: scan the frame bits and count 0s preceded by 1,1 in the same frame
    function automatic int exp_cnt(input logic [WIDTH-1:0] d, input int l);
        int c;
        logic [WIDTH-1:0] bits;
        c = 0;
        bits = d;
        for (int i = 2; i < l; i++) begin
            if (bits[WIDTH-1-i] == 1'b0) begin
                if (bits[WIDTH-i] && bits[WIDTH+1-i]) c++;
            end
        end
        if (c > CNT_MAX) c = CNT_MAX;
        return c;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_x"}, 32'(x), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Called at a negedge in an IDLE cycle; returns at a negedge of the following IDLE cycle
    task automatic send(input logic [WIDTH-1:0] d, input int l, input bit inj);
        logic [WIDTH-1:0] bits;
        int ec;
        bits = d;
        ec = exp_cnt(d, l);
        start = 1'b1; data = d; len = 5'(l);
        @(negedge clk);
        for (int i = 0; i < l; i++) begin
            check("bit_x", 32'(x), 32'(bits[WIDTH-1-i]));
            check("bit_valid", 32'(valid), 32'd1);
            check("bit_busy", 32'(busy), 32'd1);
            check("bit_done", 32'(done), 32'd0);
            check("bit_err", 32'(err), 32'd0);
            start = inj ? 1'($urandom_range(0, 1)) : 1'b0;
            data  = 16'($urandom);
            len   = 5'($urandom_range(0, 31));
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_x", 32'(x), 32'd0);
        check("done_valid", 32'(valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_cnt", 32'(cnt110), 32'(ec));
        start = inj;
        len   = 5'($urandom_range(0, 31));
        @(negedge clk);
        check_quiet("after_done");
        check("after_done_err", 32'(err), 32'd0);
        check("held_cnt", 32'(cnt110), 32'(ec));
        last_cnt = ec;
        start = 1'b0;
    endtask

    task automatic try_bad(input int l);
        start = 1'b1; len = 5'(l); data = 16'($urandom);
        @(negedge clk);
        check("err_pulse", 32'(err), 32'd1);
        check("err_valid", 32'(valid), 32'd0);
        check("err_cnt", 32'(cnt110), 32'(last_cnt));
        start = 1'b0;
        @(negedge clk);
        check("err_clear", 32'(err), 32'd0);
        check("err_valid2", 32'(valid), 32'd0);
        check("err_cnt2", 32'(cnt110), 32'(last_cnt));
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        checks = 0; errors = 0; last_cnt = 0;
        rst = 1'b1; start = 1'b0; data = '0; len = '0;
        #2;
        check_quiet("rst");
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(cnt110), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_quiet("idle");
        end

        send(16'hD800, 5, 1'b0);
        send(16'h6AC5, 16, 1'b0);
        try_bad(0);
        try_bad(17);
        send(16'hDB6D, 16, 1'b0);          // five 110s: exercises saturation
        send(16'hA5F0, 8, 1'b1);           // start pulsed throughout the frame and in DONE
        send(16'h8000, 1, 1'b0);

        // Asynchronous reset mid-frame at bit 3
        start = 1'b1; data = 16'hF0F0; len = 5'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_quiet("async_rst");
        check("async_rst_cnt", 32'(cnt110), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_rst");
        send(16'hC000, 3, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                try_bad(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 31)));
            end
            send(rd, (n % 10 == 0) ? WIDTH : int'($urandom_range(1, WIDTH)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
